// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer that reuses one 4-bit ripple-carry slice,
// one nibble per clock (LSB nibble first), with a start/busy/done handshake.

module adder4 (
  input  logic       carryin,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       carryout
);
  logic c;

  // NOTE: combinational blocks give every output a default first, so no path leaves one unassigned (which would infer a latch).
  always_comb begin
    s = '0;
    c = carryin;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    carryout = c;
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] next_work;

  logic [3:0] slice_x;
  logic [3:0] slice_y;
  logic       slice_cin;
  logic [3:0] slice_s;
  logic       slice_cout;
  logic       last;

  adder4 u_slice (
    .carryin  (slice_cin),
    .x        (slice_x),
    .y        (slice_y),
    .s        (slice_s),
    .carryout (slice_cout)
  );

  // Slice inputs are tied to zero outside RUN so idle cycles stay X-free.
  always_comb begin
    slice_x   = '0;
    slice_y   = '0;
    slice_cin = 1'b0;
    next_work = work;
    if (state == RUN) begin
      slice_x   = op_a[4*idx +: 4];
      slice_y   = op_b[4*idx +: 4];
      slice_cin = carry;
      next_work[4*idx +: 4] = slice_s;
    end
  end

  assign last = (idx == IW'(NIB - 1));
  assign busy = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work  <= next_work;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            // Subtraction reuses the add path: overflow compares signs of A and ~B.
            sum   <= next_work;
            cout  <= slice_cout;
            ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) & (slice_s[3] != op_a[WIDTH-1]);
            done  <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16) with hand-computed results.

module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operation and let the sampling edge take it.
  task automatic go(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    a     = av;
    b     = bv;
    sub   = sv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called just after the sampling edge; ends in the done cycle.
  task automatic finish_op(input string tag, input logic [15:0] held,
                           input logic [15:0] es, input logic ec, input logic eo);
    for (int i = 0; i < 4; i++) begin
      check({tag, " busy"}, busy, 16'd1);
      check({tag, " done early"}, done, 16'd0);
      check({tag, " sum held"}, sum, held);
      step();
    end
    check({tag, " done"}, done, 16'd1);
    check({tag, " busy end"}, busy, 16'd0);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, 16'(ec));
    check({tag, " ovf"}, ovf, 16'(eo));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("rst busy", busy, 16'd0);
    check("rst done", done, 16'd0);
    check("rst sum", sum, 16'h0000);
    check("rst cout", cout, 16'd0);
    check("rst ovf", ovf, 16'd0);
    rst = 1'b0;
    step();

    go(16'h1234, 16'h0FFF, 1'b0);
    finish_op("add1", 16'h0000, 16'h2233, 1'b0, 1'b0);
    go(16'hFFFF, 16'h0001, 1'b0);
    finish_op("add_carry", 16'h2233, 16'h0000, 1'b1, 1'b0);
    go(16'h7FFF, 16'h0001, 1'b0);
    finish_op("add_ovf", 16'h0000, 16'h8000, 1'b0, 1'b1);
    go(16'h0005, 16'h0007, 1'b1);
    finish_op("sub_borrow", 16'h8000, 16'hFFFE, 1'b0, 1'b0);
    go(16'h8000, 16'h0001, 1'b1);
    finish_op("sub_ovf", 16'hFFFE, 16'h7FFF, 1'b1, 1'b1);
    go(16'h1234, 16'h1234, 1'b1);
    finish_op("sub_zero", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    step();
    check("idle after done", done, 16'd0);

    // Restart and operand changes while busy must not disturb the operation.
    go(16'h1111, 16'h2222, 1'b0);
    a     = 16'h0F0F;
    b     = 16'h0F0F;
    sub   = 1'b1;
    start = 1'b1;
    finish_op("ignore_start", 16'h0000, 16'h3333, 1'b0, 1'b0);
    start = 1'b0;
    step();
    check("not queued busy", busy, 16'd0);
    check("not queued done", done, 16'd0);
    check("not queued sum", sum, 16'h3333);

    // Second start lands in the done cycle of the first.
    go(16'h0001, 16'h0002, 1'b0);
    finish_op("b2b_first", 16'h3333, 16'h0003, 1'b0, 1'b0);
    go(16'h00FF, 16'h0001, 1'b0);
    finish_op("b2b_second", 16'h0003, 16'h0100, 1'b0, 1'b0);
    step();

    // Abort with reset during the second RUN cycle.
    go(16'h1234, 16'h0FFF, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", busy, 16'd0);
    check("abort done", done, 16'd0);
    check("abort sum", sum, 16'h0000);
    check("abort cout", cout, 16'd0);
    check("abort ovf", ovf, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort no done", done, 16'd0);
    end
    go(16'h0005, 16'h0007, 1'b1);
    finish_op("after_abort", 16'h0000, 16'hFFFE, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by time-sharing one 4-bit ripple-carry adder slice (adder4: carryin, X, Y, S, carryout), one nibble per clock, LSB nibble first.
- Handles operand capture, carry chaining between nibbles, result assembly, flag generation and the start/busy/done handshake.
- Sits between a requester (ALU/accumulator logic) and the shared adder slice. Trades NIB = WIDTH/4 cycles of latency for a single small adder.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and ≥4.
- NIB, derived WIDTH/4, number of nibble steps. Not user-overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only when idle.
- sub  in  1  0 = A+B, 1 = A−B. Sampled with start.
- a  in  WIDTH  operand A. Sampled with start.
- b  in  WIDTH  operand B. Sampled with start.
- busy  out  1  high while a nibble sequence is in progress.
- done  out  1  one-cycle pulse: result, cout and ovf updated.
- sum  out  WIDTH  result register.
- cout  out  1  final carry. For sub, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0. Internal state=IDLE, nibble index=0, carry reg=0, working reg=0.
- Reset mid-operation aborts the sequence. Outputs take reset values on the next edge. No done pulse is generated.
- States: IDLE and RUN.
- IDLE, start=1 on edge k:
  - Latch A=a and B'=(sub ? ~b : b).
  - Carry reg = sub.
  - Index = 0.
  - busy=1 after edge k; go to RUN.
- RUN, edge k+1+i for i = 0..NIB−1:
  - Adder inputs: X=A[4i+3:4i], Y=B'[4i+3:4i], carryin = carry reg.
  - Write S into working[4i+3:4i]; carry reg = carryout; index++.
- On the final nibble edge (i = NIB−1):
  - sum = full working value, including the final nibble.
  - cout = carryout.
  - ovf = (A[W−1] == B'[W−1]) & (S[3] != A[W−1]).
  - busy=0, done=1 for exactly that next cycle; return to IDLE.
- Latency: done and valid sum are visible NIB cycles after the edge that sampled start. Throughput is one operation per NIB cycles.
- sum, cout and ovf hold their previous values throughout RUN. They change only on the completion edge (or reset).
- start while busy=1 is ignored. Not queued.
- start asserted during the done cycle is accepted, because the block is IDLE then. Back-to-back operations have no gap cycle.
- a, b and sub may change freely after the sampling edge without affecting the operation in flight.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Adder inputs are don't-care in IDLE, but must be driven to 0 there to keep simulation X-free.

Test Plan (WIDTH=16):
- Add: start with a=0x1234, b=0x0FFF, sub=0 → busy for 4 cycles; done pulses 4 cycles after the start edge; sum=0x2233, cout=0, ovf=0.
- Carry/overflow edges:
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005−0x0007 → sum=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
  - 0x1234−0x1234 → sum=0x0000, cout=1.
- Handshake: start re-asserted with different operands during busy → ignored; result matches the first operands. Operands changed after the sampling edge → no effect.
- Back-to-back: second start asserted in the done cycle → second busy begins immediately; second done 4 cycles later with the correct result. First result held until then.
- Reset mid-op: rst at RUN cycle 2 → next cycle busy=0, done=0, sum=0; a new start afterwards completes normally.
